quad_core_mem_arbiter: RTL
==========================

// Module: quad_core_mem_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares the single memory port among the four cores.
//   Captures the winning core's request into internal enabled registers.
//   Drives the memory valid/ready handshake, then returns read data plus a one-cycle ack to the winner.
//   Sits between the per-core load/store units and the shared memory.
//
// PARAMETERS
//   NCORES   4    number of requesters; >= 2, 4 in this processor
//   AW       32   address width
//   DW       32   data width
//   TIMEOUT  255  max REQ cycles without mem_ready before abort; 0 = wait forever
//
// PORTS
//   clk          in   1                  clock, rising edge
//   reset_n      in   1                  reset: asynchronous, active-high (asserted when 1)
//   core_req     in   NCORES             level request per core, held until its core_ack
//   core_we      in   NCORES             1 = write, 0 = read
//   core_addr    in   NCORES*AW          core i at [i*AW +: AW]
//   core_wdata   in   NCORES*DW          core i at [i*DW +: DW]
//   core_ack     out  NCORES             one-hot, one-cycle completion pulse
//   core_err     out  NCORES             pulses with core_ack on timeout abort
//   core_rdata   out  DW                 read data of last completed read
//   mem_valid    out  1                  request valid to memory
//   mem_we       out  1                  captured write enable
//   mem_addr     out  AW                 captured address
//   mem_wdata    out  DW                 captured write data
//   mem_ready    in   1                  memory accepts/completes the request this cycle
//   mem_rdata    in   DW                 read data, valid when mem_ready=1
//   grant_id     out  $clog2(NCORES)     current/last granted core
//   busy         out  1                  1 in REQ or RESP
//
// BEHAVIOUR
//   - Reset (reset_n=1, async):
//     - State=IDLE; rr pointer=0; wait counter=0.
//     - All outputs 0 (core_ack, core_err, core_rdata, mem_*, grant_id, busy).
//     - Reset mid-transaction aborts it: no ack is issued, and mem_valid drops immediately.
//   - FSM states: IDLE -> REQ -> RESP -> IDLE.
//   - IDLE:
//     - If any core_req is high, search starting at ptr (ptr, ptr+1, ... mod NCORES).
//     - The first requester found wins.
//     - Register the winner's we/addr/wdata, set grant_id=winner, go to REQ.
//     - With no request, remain in IDLE.
//   - REQ:
//     - mem_valid=1; mem_we/addr/wdata come from the captured registers, never from live core inputs.
//     - Counter increments each REQ cycle.
//     - mem_ready=1: if read, core_rdata<=mem_rdata (writes leave core_rdata unchanged); go to RESP.
//     - Counter==TIMEOUT (TIMEOUT!=0) with no ready: go to RESP with error flagged.
//   - RESP:
//     - mem_valid=0; core_ack[grant_id]=1 for exactly one cycle; core_err[grant_id]=1 if timed out.
//     - ptr<=(grant_id+1) mod NCORES (3 wraps to 0); counter<=0; go to IDLE.
//   - Latency:
//     - core_req high sampled in IDLE at cycle 0 -> mem_valid at cycle 1.
//     - mem_ready at cycle 1 -> ack at cycle 2.
//     - Minimum 3 cycles per transaction.
//   - The core drops core_req the cycle after core_ack; a req still high in IDLE is a new request.
//   - core_req / core inputs changing during REQ or RESP: ignored; the transaction completes.
//   - mem_ready outside REQ: ignored. core_rdata holds until the next completed read.
//   - Fairness: with all cores requesting, the grant order is 0,1,2,3,0,...
//   - A lone requester is re-granted back-to-back.
//   - Counter width: $clog2(TIMEOUT+1); it must not wrap.
//
// TESTING
//   1. Single read:
//      - Stimulus: core2 req, addr=0x100, we=0; mem_ready high at 3rd REQ cycle; mem_rdata=0xDEADBEEF.
//      - Response: mem_valid on cycles 1-3, mem_addr=0x100, core_ack=4'b0100 on cycle 4, core_rdata=0xDEADBEEF.
//   2. Write:
//      - Stimulus: core1 we=1, addr=0x40, wdata=0x1234; ready tied 1.
//      - Response: mem_we=1, mem_wdata=0x1234, ack[1] on cycle 2, core_rdata unchanged.
//   3. Round-robin:
//      - Stimulus: all 4 req held; ready tied 1.
//      - Response: acks on cores 0,1,2,3,0 spaced 3 cycles apart; ptr wraps 3->0.
//   4. Timeout:
//      - Stimulus: TIMEOUT=4, mem_ready never asserted, core0 read.
//      - Response: mem_valid for 4 cycles, then core_ack[0]=core_err[0]=1; next request served normally.
//   5. Input stability:
//      - Stimulus: core3 addr changed 0x10->0x20 during REQ.
//      - Response: mem_addr stays 0x10 until RESP.
//   6. Reset mid-REQ:
//      - Stimulus: assert reset_n during REQ.
//      - Response: mem_valid=0 the same cycle, no core_ack, grant_id=0; after release, core0 wins before core1.

Source files
------------

// File: rtl/quad_core_mem_arbiter_if.sv
// Bundle of the per-core request/ack lines and the shared memory port used by quad_core_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the cores-plus-memory side.
interface quad_core_mem_arbiter_if #(
  parameter int NCORES = 4,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  localparam int IDW = $clog2(NCORES);

  logic [NCORES-1:0]    core_req;
  logic [NCORES-1:0]    core_we;
  logic [NCORES*AW-1:0] core_addr;
  logic [NCORES*DW-1:0] core_wdata;
  logic [NCORES-1:0]    core_ack;
  logic [NCORES-1:0]    core_err;
  logic [DW-1:0]        core_rdata;
  logic                 mem_valid;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_ready;
  logic [DW-1:0]        mem_rdata;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_ready, mem_rdata,
    output core_ack, core_err, core_rdata, mem_valid, mem_we, mem_addr, mem_wdata,
           grant_id, busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_ready, mem_rdata,
    input  core_ack, core_err, core_rdata, mem_valid, mem_we, mem_addr, mem_wdata,
           grant_id, busy
  );
endinterface

// File: rtl/quad_core_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NCORES load/store units.
// Each transaction walks IDLE -> REQ -> RESP, with an optional timeout abort in REQ.
module quad_core_mem_arbiter #(
  parameter int NCORES  = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset_n,
  quad_core_mem_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NCORES);
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Compared against the pre-increment count so the abort fires after exactly TIMEOUT REQ cycles.
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grantId_q, grantId_d;
  logic [CW-1:0]  waitCnt_q, waitCnt_d;
  logic           timedOut_q, timedOut_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] nextPtr;
  int             idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NCORES; i++) begin
      idx = (int'(ptr_q) + i) % NCORES;
      if (!found && bus.core_req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign nextPtr = (grantId_q == IDW'(NCORES - 1)) ? '0 : grantId_q + 1'b1;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grantId_q  <= '0;
      waitCnt_q  <= '0;
      timedOut_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grantId_q  <= grantId_d;
      waitCnt_q  <= waitCnt_d;
      timedOut_q <= timedOut_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grantId_d  = grantId_q;
    waitCnt_d  = waitCnt_q;
    timedOut_d = timedOut_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grantId_d  = winner;
          we_d       = bus.core_we[winner];
          addr_d     = bus.core_addr[winner*AW +: AW];
          wdata_d    = bus.core_wdata[winner*DW +: DW];
          timedOut_d = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (waitCnt_q != '1) begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
        // A ready in the final allowed cycle still completes normally.
        if (bus.mem_ready) begin
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end else if (TIMEOUT != 0 && waitCnt_q == LAST) begin
          timedOut_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        ptr_d     = nextPtr;
        waitCnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.core_ack = '0;
    bus.core_err = '0;
    if (state_q == RESP) begin
      bus.core_ack[grantId_q] = 1'b1;
      bus.core_err[grantId_q] = timedOut_q;
    end
  end

  assign bus.mem_valid  = (state_q == REQ);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_rdata = rdata_q;
  assign bus.grant_id   = grantId_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
